pb_debouncer: RTL and testbench
===============================

// Module: pb_debouncer
// PURPOSE
// - Input conditioning stage directly upstream of top's pb[4:0] consumer logic: takes raw,
//   asynchronous, bouncing push-button inputs and delivers clean, synchronous per-button levels.
// - Per button: 2-flop synchronizer, then a stability counter/FSM, then one-cycle press/release pulses.
// - The CPU/LED logic consumes pb_level and pb_press instead of raw pins.
// PARAMETERS
// - N_PB             5    number of push buttons
// - DEBOUNCE_CYCLES  16   consecutive identical synchronized samples required to accept a new level (>=2)
// - CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width; derived, not overridden
// PORTS
// - clk         in   1      system clock; all logic on posedge
// - rst_n       in   1      asynchronous active-low reset
// - pb          in   N_PB   raw button pins, asynchronous to clk, 1 = pressed
// - pb_level    out  N_PB   debounced level, 1 = pressed
// - pb_press    out  N_PB   one-cycle pulse on accepted 0->1 transition
// - pb_release  out  N_PB   one-cycle pulse on accepted 1->0 transition
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n=0.
// - Reset values: sync flops 0, counters 0, FSM S_LOW, pb_level/pb_press/pb_release all 0.
// - Synchronizer: s1 <= pb; s2 <= s1. Only s2 feeds the FSM. No combinational path pb->outputs.
// - Per-button FSM, states: S_LOW, S_RISE, S_HIGH, S_FALL.
//   - S_LOW:  s2=1 -> S_RISE, cnt<=1; else stay, cnt<=0.
//   - S_RISE: s2=0 -> S_LOW, cnt<=0 (bounce rejected, no pulse).
//             s2=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, pb_level<=1, pb_press<=1 for that one cycle.
//             s2=1 otherwise -> cnt<=cnt+1.
//   - S_HIGH / S_FALL: mirror of S_LOW / S_RISE with polarity inverted; acceptance sets
//     pb_level<=0 and pulses pb_release.
// - pb_level is 1 exactly in S_HIGH and S_FALL; registered output.
// - Latency: raw edge sampled by s1 at edge k -> pb_level/pulse change at edge k+1+DEBOUNCE_CYCLES
//   if pb stays stable; any opposite s2 sample before acceptance restarts the count from zero.
// - pb_press and pb_release never assert together for one button; each is exactly one cycle wide;
//   pulses never occur without a pb_level change in the same cycle.
// - Buttons are fully independent; simultaneous transitions on several buttons give simultaneous
//   pulses on the matching bits.
// - Counter saturates by construction (cleared on acceptance); no wrap-around possible.
// - Reset mid-count: counter and FSM return to S_LOW; a button held through reset release is
//   re-debounced and produces a pb_press DEBOUNCE_CYCLES+2 edges after release at earliest.
// STRUCTURE
// - Shared package pb_pkg: state typedef (S_LOW=2'b00, S_RISE=2'b01, S_HIGH=2'b11, S_FALL=2'b10)
//   and default DEBOUNCE_CYCLES constant.
// - Sub-module pb_debounce_cell: one button (synchronizer, counter, FSM, pulse regs);
//   pb_debouncer instantiates N_PB copies with a generate loop. No other logic at top level.
// TESTING (bench uses DEBOUNCE_CYCLES=4, 10-unit clock)
// - Reset: rst_n=0 with pb=5'b11111 -> all outputs 0 while in reset; after release pb_press=5'b11111
//   for exactly one cycle, pb_level=5'b11111 thereafter.
// - Clean press pb[0]: 0->1 held -> pb_level[0] and pb_press[0] rise 5 edges after s1 samples 1;
//   pb_press[0] high 1 cycle; other bits stay 0.
// - Bounce: pb[2] toggles 1,0,1,0 every cycle then holds 1 -> no pulse during toggling; single
//   pb_press[2] exactly 5 edges after the final 1 is sampled.
// - Glitch reject: pb[4] high for 3 cycles then low -> pb_level[4], pb_press[4], pb_release[4] stay 0.
// - Release + simultaneity: pb[1] and pb[3] released same cycle after debounced press ->
//   pb_release=5'b01010 for one cycle, pb_level bits 1,3 clear same edge.
// - Async reset mid-count: rst_n pulsed low in S_RISE -> outputs 0 immediately, no pulse emitted.

Source files
------------

// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and defaults for the push-button debouncer
package pb_pkg;

  // Default number of buttons and stability window in clock cycles
  localparam int PB_N               = 5;
  localparam int PB_DEBOUNCE_CYCLES = 16;

  // Per-button debounce state; bit 1 doubles as the debounced level
  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b11,
    S_FALL = 2'b10
  } pb_state_t;

endpackage

// File: rtl/pb_debounce_cell.sv
// rtl/pb_debounce_cell.sv - single-button synchronizer, stability counter and edge pulses
module pb_debounce_cell
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  pb_state_t        state;
  pb_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Two-flop synchronizer; only s2 is allowed to influence the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pb;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOW;
      cnt        <= '0;
      pb_level   <= 1'b0;
      pb_press   <= 1'b0;
      pb_release <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pb_level   <= level_nxt;
      pb_press   <= press_nxt;
      pb_release <= release_nxt;
    end
  end

  // Next-state logic: a candidate level must be seen DEBOUNCE_CYCLES times in a row
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = pb_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      S_LOW: begin
        if (s2) begin
          state_nxt = S_RISE;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_RISE: begin
        if (!s2) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s2) begin
          state_nxt = S_FALL;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_FALL: begin
        if (s2) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = S_LOW;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt     = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pb_debouncer.sv
// rtl/pb_debouncer.sv - bank of independent push-button debounce cells
module pb_debouncer
  import pb_pkg::*;
#(
  parameter int N_PB            = PB_N,
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_PB-1:0] pb,
  output logic [N_PB-1:0] pb_level,
  output logic [N_PB-1:0] pb_press,
  output logic [N_PB-1:0] pb_release
);

  // One fully independent cell per button
  for (genvar i = 0; i < N_PB; i++) begin : g_cell
    pb_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb        (pb[i]),
      .pb_level  (pb_level[i]),
      .pb_press  (pb_press[i]),
      .pb_release(pb_release[i])
    );
  end

endmodule

// File: tb/tb_pb_debouncer.sv
// tb/tb_pb_debouncer.sv - scoreboard bench for pb_debouncer with DEBOUNCE_CYCLES=4
module tb_pb_debouncer;

  localparam int N   = 5;
  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pb = '0;
  logic [N-1:0] pb_level;
  logic [N-1:0] pb_press;
  logic [N-1:0] pb_release;

  pb_debouncer #(
    .N_PB(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb        (pb),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int           at;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] level;
  } ev_t;

  ev_t          exp_q[$];
  logic [N-1:0] exp_level = '0;
  int           tests = 0;
  int           fails = 0;

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every pulse the DUT emits must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && ((pb_press | pb_release) != '0)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: press %b release %b expected none (edge %0d)",
                 pb_press, pb_release, edge_n);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check_int("pulse_edge", edge_n, ev.at);
        check_vec("pulse_press", pb_press, ev.press);
        check_vec("pulse_release", pb_release, ev.rel);
        check_vec("pulse_level", pb_level, ev.level);
      end
    end
  end

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    pb = v;
  endtask

  // Called in the same timestep as the input change: first sample is the next edge
  task automatic push(input logic [N-1:0] press, input logic [N-1:0] rel);
    ev_t ev;
    exp_level = (exp_level | press) & ~rel;
    ev.at    = edge_n + LAT;
    ev.press = press;
    ev.rel   = rel;
    ev.level = exp_level;
    exp_q.push_back(ev);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    check_int(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset with every button held
    rst_n = 1'b0;
    pb    = 5'b11111;
    wait_cyc(3);
    check_vec("reset_level", pb_level, 5'b00000);
    check_vec("reset_press", pb_press, 5'b00000);
    check_vec("reset_release", pb_release, 5'b00000);
    rst_n = 1'b1;
    push(5'b11111, 5'b00000);
    wait_cyc(LAT + 2);
    check_drained("reset_hold_press_seen");
    check_vec("reset_hold_level", pb_level, 5'b11111);
    drive(5'b00000);
    push(5'b00000, 5'b11111);
    wait_cyc(LAT + 2);
    check_drained("reset_hold_release_seen");
    check_vec("all_released_level", pb_level, 5'b00000);

    // Clean press and release of button 0
    drive(5'b00001);
    push(5'b00001, 5'b00000);
    wait_cyc(LAT + 2);
    check_drained("clean_press_seen");
    check_vec("clean_press_level", pb_level, 5'b00001);
    drive(5'b00000);
    push(5'b00000, 5'b00001);
    wait_cyc(LAT + 2);
    check_drained("clean_release_seen");

    // Bouncing button 2 settles high
    drive(5'b00100);
    drive(5'b00000);
    drive(5'b00100);
    drive(5'b00000);
    drive(5'b00100);
    push(5'b00100, 5'b00000);
    wait_cyc(LAT + 2);
    check_drained("bounce_press_seen");
    check_vec("bounce_level", pb_level, 5'b00100);
    drive(5'b00000);
    push(5'b00000, 5'b00100);
    wait_cyc(LAT + 2);
    check_drained("bounce_release_seen");

    // Three-cycle glitch on button 4 must be rejected
    drive(5'b10000);
    wait_cyc(2);
    drive(5'b00000);
    wait_cyc(LAT + 4);
    check_vec("glitch_level", pb_level, 5'b00000);
    check_drained("glitch_no_event");

    // Buttons 1 and 3 pressed and released together
    drive(5'b01010);
    push(5'b01010, 5'b00000);
    wait_cyc(LAT + 2);
    check_vec("simul_press_level", pb_level, 5'b01010);
    drive(5'b00000);
    push(5'b00000, 5'b01010);
    wait_cyc(LAT + 2);
    check_drained("simul_events_seen");
    check_vec("simul_release_level", pb_level, 5'b00000);

    // Asynchronous reset while button 0 is mid-count and button 1 is debounced high
    drive(5'b00010);
    push(5'b00010, 5'b00000);
    wait_cyc(LAT + 2);
    check_drained("pre_async_press_seen");
    drive(5'b00011);
    wait_cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset_level", pb_level, 5'b00000);
    check_vec("async_reset_press", pb_press, 5'b00000);
    check_vec("async_reset_release", pb_release, 5'b00000);
    pb = 5'b00000;
    exp_level = '0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(LAT + 4);
    check_vec("post_async_level", pb_level, 5'b00000);
    check_drained("post_async_no_event");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
